// File: rtl/peri_pkg.sv
// Shared types and defaults for the posted-write peripheral bridge.
package peri_pkg;

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_WR   = 2'd1,
    E_RD   = 2'd2
  } eng_state_e;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 1024;
  localparam logic DEF_ERR_BIT = 1'b1;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]   addr;
    logic [DEF_DATA_W-1:0]   data;
    logic [DEF_DATA_W/8-1:0] strb;
  } wq_entry_t;

endpackage

// File: rtl/peri_bridge_q_if.sv
// Request-port and peripheral-channel bundle of the bridge; master = core/peripheral side, slave = bridge.
interface peri_bridge_q_if #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WQ_DEPTH = 4
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LVL_W  = $clog2(WQ_DEPTH) + 1;

  logic              START;
  logic              WRITE;
  logic [ADDR_W-1:0] ADDRESS;
  logic [DATA_W-1:0] DATA_IN;
  logic [STRB_W-1:0] BYTE_EN;
  logic [DATA_W-1:0] DATA_OUT;
  logic              DONE;
  logic              RD_ERR;
  logic              WR_ERR;
  logic              ERR_CLR;
  logic [LVL_W-1:0]  WQ_LEVEL;
  logic              CACHE_READY_DAT;
  logic [ADDR_W-1:0] RD_ADDR_TO_PERI;
  logic              RD_ADDR_TO_PERI_VALID;
  logic              RD_ADDR_TO_PERI_READY;
  logic [ADDR_W-1:0] WR_ADDR_TO_PERI;
  logic [DATA_W-1:0] DATA_TO_PERI;
  logic [STRB_W-1:0] STRB_TO_PERI;
  logic              WR_TO_PERI_VALID;
  logic              WR_TO_PERI_READY;
  logic [DATA_W-1:0] DATA_FROM_PERI;
  logic              DATA_FROM_PERI_VALID;
  logic              DATA_FROM_PERI_READY;
  logic              TRANSACTION_COMPLETE_PERI;
  logic              PERI_ERR;

  modport master (
    output START, WRITE, ADDRESS, DATA_IN, BYTE_EN, ERR_CLR, CACHE_READY_DAT,
           RD_ADDR_TO_PERI_READY, WR_TO_PERI_READY, DATA_FROM_PERI,
           DATA_FROM_PERI_VALID, TRANSACTION_COMPLETE_PERI, PERI_ERR,
    input  DATA_OUT, DONE, RD_ERR, WR_ERR, WQ_LEVEL, RD_ADDR_TO_PERI,
           RD_ADDR_TO_PERI_VALID, WR_ADDR_TO_PERI, DATA_TO_PERI, STRB_TO_PERI,
           WR_TO_PERI_VALID, DATA_FROM_PERI_READY
  );

  modport slave (
    input  START, WRITE, ADDRESS, DATA_IN, BYTE_EN, ERR_CLR, CACHE_READY_DAT,
           RD_ADDR_TO_PERI_READY, WR_TO_PERI_READY, DATA_FROM_PERI,
           DATA_FROM_PERI_VALID, TRANSACTION_COMPLETE_PERI, PERI_ERR,
    output DATA_OUT, DONE, RD_ERR, WR_ERR, WQ_LEVEL, RD_ADDR_TO_PERI,
           RD_ADDR_TO_PERI_VALID, WR_ADDR_TO_PERI, DATA_TO_PERI, STRB_TO_PERI,
           WR_TO_PERI_VALID, DATA_FROM_PERI_READY
  );

endinterface

// File: rtl/peri_wq_fifo.sv
// Posted-write queue: synchronous FIFO with extra-MSB pointers and a registered occupancy count.
module peri_wq_fifo
  import peri_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wq_entry_t
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  T                       wdata_i,
  input  logic                   pop_i,
  output T                       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  T            mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic [AW:0] level_q;
  logic [AW:0] level_d;
  logic        push_ok_s;
  logic        pop_ok_s;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o   = level_q;

  always_comb begin
    level_d = level_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + {{AW{1'b0}}, 1'b1};
      2'b01:   level_d = level_q - {{AW{1'b0}}, 1'b1};
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      level_q <= level_d;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/peri_bridge_q.sv
// Peripheral bridge with posted-write queue, strict read-after-write ordering and per-transaction timeout.
module peri_bridge_q
  import peri_pkg::*;
#(
  parameter int              ADDR_W   = DEF_ADDR_W,
  parameter int              DATA_W   = DEF_DATA_W,
  parameter int              WQ_DEPTH = 4,
  parameter int              TIMEOUT  = DEF_TIMEOUT,
  parameter logic [DATA_W-1:0] ERR_DATA = {DATA_W{DEF_ERR_BIT}}
) (
  input logic            CLK,
  input logic            RESETN,
  peri_bridge_q_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LVL_W  = $clog2(WQ_DEPTH) + 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } entry_t;

  eng_state_e        state_q;
  logic [CNT_W-1:0]  tmo_q;
  logic              done_q;
  logic              rd_err_q;
  logic              wr_err_q;
  logic              busy_rd_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] data_out_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [STRB_W-1:0] wr_strb_q;
  logic              wr_valid_q;
  logic              rd_valid_q;
  logic              dfp_ready_q;

  entry_t            head_s;
  entry_t            wdata_s;
  logic              full_s;
  logic              empty_s;
  logic [LVL_W-1:0]  level_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic              done_ack_s;
  logic              tmo_hit_s;
  logic              wr_err_set_s;

  assign accept_s   = bus.START && !done_q && !busy_rd_q;
  assign push_s     = accept_s && bus.WRITE && !full_s;
  assign done_ack_s = done_q && bus.CACHE_READY_DAT;
  assign tmo_hit_s  = (TIMEOUT != 0) && (tmo_q == CNT_W'(TIMEOUT - 1));
  assign wdata_s    = {bus.ADDRESS, bus.DATA_IN, bus.BYTE_EN};
  // The head entry stays queued while on the bus, so occupancy counts in-flight writes too.
  assign pop_s        = (state_q == E_WR) && (bus.TRANSACTION_COMPLETE_PERI || tmo_hit_s);
  assign wr_err_set_s = (state_q == E_WR) &&
                        (bus.TRANSACTION_COMPLETE_PERI ? bus.PERI_ERR : tmo_hit_s);

  peri_wq_fifo #(
    .DEPTH (WQ_DEPTH),
    .T     (entry_t)
  ) u_wq (
    .clk_i   (CLK),
    .rst_n_i (RESETN),
    .push_i  (push_s),
    .wdata_i (wdata_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .level_o (level_s)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= E_IDLE;
      tmo_q       <= '0;
      done_q      <= 1'b0;
      rd_err_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      busy_rd_q   <= 1'b0;
      rd_addr_q   <= '0;
      data_out_q  <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strb_q   <= '0;
      wr_valid_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      dfp_ready_q <= 1'b0;
    end else begin
      if (done_ack_s) begin
        done_q   <= 1'b0;
        rd_err_q <= 1'b0;
      end else if (push_s) begin
        done_q <= 1'b1;
      end
      if (accept_s && !bus.WRITE) begin
        busy_rd_q <= 1'b1;
        rd_addr_q <= bus.ADDRESS;
      end
      if (wr_err_set_s)     wr_err_q <= 1'b1;
      else if (bus.ERR_CLR) wr_err_q <= 1'b0;

      case (state_q)
        E_IDLE: begin
          tmo_q <= '0;
          if (!empty_s) begin
            state_q    <= E_WR;
            wr_addr_q  <= head_s.addr;
            wr_data_q  <= head_s.data;
            wr_strb_q  <= head_s.strb;
            wr_valid_q <= 1'b1;
          end else if (busy_rd_q) begin
            state_q     <= E_RD;
            rd_valid_q  <= 1'b1;
            dfp_ready_q <= 1'b1;
          end
        end
        E_WR: begin
          tmo_q <= tmo_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (wr_valid_q && bus.WR_TO_PERI_READY) wr_valid_q <= 1'b0;
          if (bus.TRANSACTION_COMPLETE_PERI || tmo_hit_s) begin
            wr_valid_q <= 1'b0;
            state_q    <= E_IDLE;
          end
        end
        E_RD: begin
          tmo_q <= tmo_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (rd_valid_q && bus.RD_ADDR_TO_PERI_READY) rd_valid_q <= 1'b0;
          if (dfp_ready_q && bus.DATA_FROM_PERI_VALID) begin
            dfp_ready_q <= 1'b0;
            data_out_q  <= bus.DATA_FROM_PERI;
          end
          // Completion outranks a coincident timeout; an error or timeout replaces any captured data.
          if (bus.TRANSACTION_COMPLETE_PERI || tmo_hit_s) begin
            rd_valid_q  <= 1'b0;
            dfp_ready_q <= 1'b0;
            busy_rd_q   <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= E_IDLE;
            if (bus.TRANSACTION_COMPLETE_PERI && !bus.PERI_ERR) begin
              rd_err_q <= 1'b0;
            end else begin
              rd_err_q   <= 1'b1;
              data_out_q <= ERR_DATA;
            end
          end
        end
        default: state_q <= E_IDLE;
      endcase
    end
  end

  assign bus.DONE                  = done_q;
  assign bus.RD_ERR                = rd_err_q;
  assign bus.WR_ERR                = wr_err_q;
  assign bus.DATA_OUT              = data_out_q;
  assign bus.WQ_LEVEL              = level_s;
  assign bus.RD_ADDR_TO_PERI       = rd_addr_q;
  assign bus.RD_ADDR_TO_PERI_VALID = rd_valid_q;
  assign bus.DATA_FROM_PERI_READY  = dfp_ready_q;
  assign bus.WR_ADDR_TO_PERI       = wr_addr_q;
  assign bus.DATA_TO_PERI          = wr_data_q;
  assign bus.STRB_TO_PERI          = wr_strb_q;
  assign bus.WR_TO_PERI_VALID      = wr_valid_q;

endmodule
